mesi_bus_arbiter: RTL and testbench
===================================

// Module: mesi_bus_arbiter
// PURPOSE
// - Snoopy-bus front end for the MESI system. Takes one pending bus_msg_t from each of
//   NUM_CPUS cache controllers and grants the bus round-robin. Broadcasts the winner to
//   all snoopers, then holds the bus until the transaction completes:
//   snoop acks collected, then crossbar data or memory ack received.
// - Consumes the types package (bus_msg_t, bus_tx_t). Feeds every cache snoop port and
//   the xbar/memory side.
// PARAMETERS
// - NUM_CPUS       types::NUM_CPUS  requesters / snoopers
// - SNOOP_TIMEOUT  16               max cycles in SNOOP before missing acks are forced
// PORTS
// - clk             in   1                   clock; all flops on posedge
// - rst_n           in   1                   asynchronous, active-low reset
// - req_i           in   NUM_CPUS x bus_msg_t  per-CPU request; held until accepted
// - req_ready_o     in   -- see next line
// - req_ready_o     out  NUM_CPUS            one-hot, 1-cycle pulse: request accepted
// - bus_o           out  bus_msg_t           broadcast transaction; valid=1 for 1 cycle
// - snoop_done_i    in   NUM_CPUS            per-cache snoop finished (level, sampled in SNOOP)
// - snoop_shared_i  in   NUM_CPUS            snooper held line valid (S/E/M)
// - xbar_done_i     in   1                   line data delivered to requester (Rd/Rdx)
// - mem_ack_i       in   1                   memory accepted writeback (Flush)
// - shared_o        out  1                   1-cycle pulse with completion: other copy exists
// - done_o          out  1                   1-cycle pulse: transaction retired
// - busy_o          out  1                   FSM not in IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, rr_ptr=0, bus_o='0 (valid=0, bus_tx=Bus_Idle), req_ready_o=0,
//   shared_o=0, done_o=0, busy_o=0, timeout counter=0, shared accumulator=0.
// - Eligible request: req_i[k].valid && req_i[k].bus_tx != Bus_Idle.
//   valid with Bus_Idle is ignored and never acked.
// - Arbitration (IDLE only): search eligible CPUs starting at rr_ptr, wrapping mod NUM_CPUS.
//   The winner w is registered.
// - Next cycle (GRANT): req_ready_o[w]=1, bus_o=req_i[w] latched copy with
//   source=w (zero-extended) and valid=1. Grant-to-broadcast latency is 1 cycle.
//   rr_ptr <= (w+1) mod NUM_CPUS.
// - FSM states: IDLE -> GRANT -> SNOOP -> WAIT_DATA -> IDLE.
//   - SNOOP: wait until (snoop_done_i | (1<<w)) is all-ones.
//     The requester's own bit is masked.
//     OR in snoop_shared_i of non-requesters each cycle.
//     If the timeout counter reaches SNOOP_TIMEOUT-1, leave SNOOP anyway.
//   - SNOOP exit by bus_tx:
//     - Bus_Upg: retire directly.
//     - Bus_Rd, Bus_Rdx: go to WAIT_DATA and wait for xbar_done_i.
//   - Bus_Flush: skip SNOOP (GRANT -> WAIT_DATA) and wait for mem_ack_i.
//   - A done/ack already high in the cycle WAIT_DATA is entered counts; no extra cycle.
//   - Retire: done_o=1 and shared_o=accumulated shared for one cycle; return to IDLE.
//     Arbitration resumes in that same IDLE cycle.
//     Min Upg occupancy: GRANT + SNOOP(1) + IDLE = back-to-back grants every 3 cycles.
// - bus_o.valid is high only in GRANT. Fields other than valid hold their last value
//   until the next grant.
// - Simultaneous events:
//   - xbar_done_i or mem_ack_i outside WAIT_DATA: ignored.
//   - snoop_done_i outside SNOOP: ignored.
//   - A request that drops valid before acceptance is simply not granted. No error.
// - A requester is never re-granted while its own transaction is in flight.
//   Each CPU has only one outstanding transaction by construction.
// - Reset mid-transaction: immediate return to reset values; the in-flight transaction
//   is abandoned. Caches are reset with the same rst_n.
// STRUCTURE
// - Package types: add arb_state_t {ARB_IDLE, ARB_GRANT, ARB_SNOOP, ARB_WAIT_DATA}.
//   SNOOP_TIMEOUT default lives in types as well.
// - Sub-module rr_arbiter (NUM_CPUS): combinational find-first-from-pointer.
//   Inputs: req vector and ptr. Outputs: one-hot grant and index. Reused by the xbar.
// - Everything else (FSM, latches, counter, shared accumulator) is in this module.
// TESTING
// - Single Rd: CPU1 Bus_Rd addr=6'h2A, snoopers ack the next cycle, CPU2 shared=1,
//   xbar_done 2 cycles later.
//   -> bus_o.source=1 valid 1 cycle; done_o and shared_o=1 together; rr_ptr=2.
// - Contention: CPUs 0,2,3 request Bus_Rdx together from rr_ptr=0.
//   -> grant order 0,2,3; each req_ready_o a single pulse; no overlap of bus_o.valid.
// - Bus_Upg from CPU3 with all acks -> retire without waiting for xbar; shared_o=0.
// - Bus_Flush from CPU0 -> no SNOOP state visited; done_o the cycle after mem_ack_i.
// - Timeout: CPU2 never asserts snoop_done with SNOOP_TIMEOUT=16
//   -> SNOOP exits after exactly 16 cycles; transaction completes normally.
// - rst_n asserted low during WAIT_DATA -> all outputs 0 asynchronously.
//   After release, the pending request re-arbitrates from CPU0.

Source files
------------

// File: rtl/mesi_bus_arbiter_pkg.sv
// Shared types for the MESI snoopy bus: transaction codes, bus message and arbiter states.
package mesi_bus_arbiter_pkg;

    localparam int DEF_NUM_CPUS      = 4;
    localparam int DEF_SNOOP_TIMEOUT = 16;
    localparam int ADDR_W            = 6;
    localparam int SRC_W             = 4;

    typedef enum logic [2:0] {
        Bus_Idle  = 3'd0,
        Bus_Rd    = 3'd1,
        Bus_Rdx   = 3'd2,
        Bus_Upg   = 3'd3,
        Bus_Flush = 3'd4
    } bus_tx_t;

    typedef struct packed {
        logic              valid;
        bus_tx_t           bus_tx;
        logic [ADDR_W-1:0] addr;
        logic [SRC_W-1:0]  source;
    } bus_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_SNOOP,
        ARB_WAIT_DATA
    } arb_state_t;

    // A valid message carrying Bus_Idle is a no-op and never competes for the bus.
    function automatic logic eligible(bus_msg_t m);
        return m.valid && (m.bus_tx != Bus_Idle);
    endfunction

endpackage

// File: rtl/mesi_bus_arbiter_if.sv
// Bus-side bundle of the snoopy arbiter: requests, broadcast, snoop responses, completion.
interface mesi_bus_if #(
    parameter int NUM_CPUS = mesi_bus_arbiter_pkg::DEF_NUM_CPUS
);
    import mesi_bus_arbiter_pkg::*;

    bus_msg_t [NUM_CPUS-1:0] req;
    logic     [NUM_CPUS-1:0] req_ready;
    bus_msg_t                bus;
    logic     [NUM_CPUS-1:0] snoop_done;
    logic     [NUM_CPUS-1:0] snoop_shared;
    logic                    xbar_done;
    logic                    mem_ack;
    logic                    shared;
    logic                    done;
    logic                    busy;

    // master: the arbiter that owns the bus; slave: caches, xbar and memory around it.
    modport master (
        input  req, snoop_done, snoop_shared, xbar_done, mem_ack,
        output req_ready, bus, shared, done, busy
    );

    modport slave (
        output req, snoop_done, snoop_shared, xbar_done, mem_ack,
        input  req_ready, bus, shared, done, busy
    );

endinterface

// File: rtl/mesi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) gnt = N'(1) << idx;
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snoopy-bus front end: round-robin grant, broadcast, then hold the bus until snoops
// and data (or memory ack) retire the transaction.
module mesi_bus_arbiter
    import mesi_bus_arbiter_pkg::*;
#(
    parameter int NUM_CPUS      = DEF_NUM_CPUS,
    parameter int SNOOP_TIMEOUT = DEF_SNOOP_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    mesi_bus_if.master arb
);

    localparam int IDX_W = $clog2(NUM_CPUS);
    localparam int TMO_W = $clog2(SNOOP_TIMEOUT);

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr, win, gnt_idx, next_ptr;
    logic [NUM_CPUS-1:0] elig, gnt_oh, own, ready_q;
    logic                gnt_any;
    bus_msg_t            bus_q, grant_msg;
    logic [TMO_W-1:0]    tmo;
    logic                acc, shared_now, snoop_exit, data_in;
    logic                shared_q, done_q, busy_q;

    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_CPUS; k++) elig[k] = eligible(arb.req[k]);
    end

    rr_arbiter #(.N(NUM_CPUS), .IW(IDX_W)) u_rr (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        grant_msg        = arb.req[gnt_idx];
        grant_msg.valid  = 1'b1;
        grant_msg.source = SRC_W'(gnt_idx);
    end

    assign next_ptr   = (gnt_idx == IDX_W'(NUM_CPUS - 1)) ? '0 : gnt_idx + IDX_W'(1);
    // The requester never snoops its own transaction: its ack and shared bits are masked.
    assign own        = NUM_CPUS'(1) << win;
    assign shared_now = acc | (|(arb.snoop_shared & ~own));
    assign snoop_exit = (&(arb.snoop_done | own)) || (tmo == TMO_W'(SNOOP_TIMEOUT - 1));
    assign data_in    = (bus_q.bus_tx == Bus_Flush) ? arb.mem_ack : arb.xbar_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            win      <= '0;
            bus_q    <= '0;
            ready_q  <= '0;
            tmo      <= '0;
            acc      <= 1'b0;
            shared_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q     <= '0;
            bus_q.valid <= 1'b0;
            done_q      <= 1'b0;
            shared_q    <= 1'b0;
            case (state)
                ARB_IDLE: if (gnt_any) begin
                    state   <= ARB_GRANT;
                    busy_q  <= 1'b1;
                    win     <= gnt_idx;
                    rr_ptr  <= next_ptr;
                    ready_q <= gnt_oh;
                    bus_q   <= grant_msg;
                end
                ARB_GRANT: begin
                    tmo   <= '0;
                    acc   <= 1'b0;
                    state <= (bus_q.bus_tx == Bus_Flush) ? ARB_WAIT_DATA : ARB_SNOOP;
                end
                ARB_SNOOP: begin
                    tmo <= tmo + TMO_W'(1);
                    acc <= shared_now;
                    if (snoop_exit) begin
                        if (bus_q.bus_tx == Bus_Upg) begin
                            state    <= ARB_IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            shared_q <= shared_now;
                        end else begin
                            state <= ARB_WAIT_DATA;
                        end
                    end
                end
                ARB_WAIT_DATA: if (data_in) begin
                    state    <= ARB_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    shared_q <= acc;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign arb.req_ready = ready_q;
    assign arb.bus       = bus_q;
    assign arb.shared    = shared_q;
    assign arb.done      = done_q;
    assign arb.busy      = busy_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench: stimulus pushes expected grants/retirements, a monitor pops and compares,
// a responder plays the snoopers, xbar and memory.
module tb_mesi_bus_arbiter;
    import mesi_bus_arbiter_pkg::*;

    localparam int N = DEF_NUM_CPUS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mesi_bus_if #(.NUM_CPUS(N)) bif();

    mesi_bus_arbiter #(.NUM_CPUS(N), .SNOOP_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        src;
        bus_tx_t   tx;
        logic [5:0] addr;
        bit        shared;
        int        lat;   // grant cycle to done cycle
        int        gap;   // cycles since previous grant, -1 = unchecked
    } exp_t;

    exp_t   q[$];
    exp_t   cur;
    bit     inflight = 1'b0;
    bit     chk_after = 1'b0;
    int     tests = 0, fails = 0;
    int     cyc = 0, g_cyc = 0, last_g = 0;
    logic [N-1:0] cfg_nodone = '0, cfg_shared = '0;
    int     cfg_d = 2;

    task automatic check(string nm, int act, int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic flag(string nm);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Expectations must be pushed in the order the grants are predicted to occur.
    task automatic issue(int cpu, bus_tx_t tx, logic [5:0] addr, bit sh, int lat, int gap);
        exp_t e;
        bif.req[cpu] = '{valid: 1'b1, bus_tx: tx, addr: addr, source: '0};
        e = '{src: cpu, tx: tx, addr: addr, shared: sh, lat: lat, gap: gap};
        q.push_back(e);
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !inflight) return;
        end
        flag("drain_timeout");
    endtask

    task automatic wait_grant(int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bif.bus.valid) return;
        end
        flag("grant_timeout");
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters hold their message until accepted.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++)
            if (bif.req_ready[k]) bif.req[k].valid = 1'b0;
    end

    // Snoopers ack with the grant; xbar/memory ack is raised cfg_d cycles after grant
    // and held until the retirement is seen.
    initial forever begin
        bus_tx_t tx;
        @(negedge clk);
        if (rst_n && bif.bus.valid) begin
            tx = bif.bus.bus_tx;
            if (tx != Bus_Flush) begin
                bif.snoop_done   = ~cfg_nodone;
                bif.snoop_shared = cfg_shared;
            end
            for (int t = 1; t < 200; t++) begin
                @(negedge clk);
                if (!rst_n || bif.done) break;
                if (t == 2) begin
                    bif.snoop_done   = '0;
                    bif.snoop_shared = '0;
                end
                if (t == cfg_d) begin
                    if (tx == Bus_Flush)    bif.mem_ack   = 1'b1;
                    else if (tx != Bus_Upg) bif.xbar_done = 1'b1;
                end
            end
            bif.snoop_done   = '0;
            bif.snoop_shared = '0;
            bif.xbar_done    = 1'b0;
            bif.mem_ack      = 1'b0;
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (chk_after) begin
                check("valid_one_cycle", int'(bif.bus.valid), 0);
                check("ready_one_cycle", int'(bif.req_ready), 0);
                chk_after = 1'b0;
            end
            if (bif.bus.valid) begin
                if (q.size() == 0) begin
                    flag("unexpected_grant");
                end else begin
                    e = q.pop_front();
                    check("grant_source", int'(bif.bus.source), e.src);
                    check("grant_tx", int'(bif.bus.bus_tx), int'(e.tx));
                    check("grant_addr", int'(bif.bus.addr), int'(e.addr));
                    check("grant_ready", int'(bif.req_ready), 1 << e.src);
                    check("grant_busy", int'(bif.busy), 1);
                    if (e.gap >= 0) check("grant_gap", cyc - last_g, e.gap);
                    cur       = e;
                    inflight  = 1'b1;
                    g_cyc     = cyc;
                    last_g    = cyc;
                    chk_after = 1'b1;
                end
            end
            if (bif.done) begin
                if (!inflight) begin
                    flag("unexpected_done");
                end else begin
                    check("done_shared", int'(bif.shared), int'(cur.shared));
                    check("done_latency", cyc - g_cyc, cur.lat);
                    check("done_busy", int'(bif.busy), 0);
                    inflight = 1'b0;
                end
            end
        end
    end

    initial begin
        bif.req          = '0;
        bif.snoop_done   = '0;
        bif.snoop_shared = '0;
        bif.xbar_done    = 1'b0;
        bif.mem_ack      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bus", int'(bif.bus), 0);
        check("rst_ready", int'(bif.req_ready), 0);
        check("rst_done", int'(bif.done), 0);
        check("rst_shared", int'(bif.shared), 0);
        check("rst_busy", int'(bif.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from ptr 0: 0,2,3; Rdx with data at grant+2 -> done at grant+3.
        cfg_nodone = '0; cfg_shared = '0; cfg_d = 2;
        issue(0, Bus_Rdx, 6'h10, 1'b0, 3, -1);
        issue(2, Bus_Rdx, 6'h11, 1'b0, 3, 4);
        issue(3, Bus_Rdx, 6'h12, 1'b0, 3, 4);
        wait_idle(100);

        // Single Rd from CPU1, CPU2 shared; xbar at grant+3 -> done at grant+4.
        cfg_shared = 4'b0100; cfg_d = 3;
        issue(1, Bus_Rd, 6'h2A, 1'b1, 4, -1);
        wait_idle(50);

        // ptr now 2: CPU3 before CPU1; Upg back-to-back every 3 cycles.
        // CPU3's own shared bit is masked; for CPU1 it counts.
        cfg_shared = 4'b1000; cfg_d = 2;
        issue(3, Bus_Upg, 6'h05, 1'b0, 2, -1);
        issue(1, Bus_Upg, 6'h06, 1'b1, 2, 3);
        wait_idle(50);

        // Flush skips SNOOP; mem_ack present on WAIT_DATA entry -> done at grant+2.
        cfg_shared = 4'b1111; cfg_d = 1;
        issue(0, Bus_Flush, 6'h3F, 1'b0, 2, -1);
        wait_idle(50);

        // Timeout: CPU2 never acks -> 16 SNOOP cycles; early xbar_done is ignored.
        bif.req[3] = '{valid: 1'b1, bus_tx: Bus_Idle, addr: 6'h01, source: '0};
        cfg_nodone = 4'b0100; cfg_shared = 4'b0001; cfg_d = 3;
        issue(1, Bus_Rd, 6'h07, 1'b1, 18, -1);
        wait_idle(100);
        repeat (5) @(negedge clk);

        // Reset during WAIT_DATA; afterwards CPU1 precedes CPU3 (ptr back to 0).
        cfg_nodone = '0; cfg_shared = '0; cfg_d = 50;
        issue(2, Bus_Rd, 6'h20, 1'b0, 0, -1);
        wait_grant(20);
        issue(1, Bus_Rd, 6'h21, 1'b0, 3, -1);
        issue(3, Bus_Rdx, 6'h22, 1'b0, 3, 4);
        repeat (3) @(negedge clk);
        check("busy_in_wait", int'(bif.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(bif.busy), 0);
        check("async_rst_bus", int'(bif.bus), 0);
        check("async_rst_ready", int'(bif.req_ready), 0);
        check("async_rst_done", int'(bif.done), 0);
        check("async_rst_shared", int'(bif.shared), 0);
        inflight = 1'b0;
        cfg_d = 2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(100);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
